// File: rtl/mem_resp_mc.sv
// mem_resp_mc: dual-bank (instruction/data) word memory with a fixed-latency request/response FSM.
// Optional build macro MEM_MISALIGN_CHECK_EN reports misaligned half/word accesses on err.
`default_nettype none

module mem_resp_mc #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_d_mem,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam int         AW       = IDX_W + 2;
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;

   logic [AW-1:0] lat_addr;
   logic [31:0]   lat_wdata;
   logic [1:0]    lat_size;
   logic          lat_uns, lat_dbank, lat_rd, lat_wr;

   logic [AW-1:0] cur_addr;
   logic [31:0]   cur_wdata;
   logic [1:0]    cur_size, eff_size, off;
   logic          cur_uns, cur_dbank, cur_rd, cur_wr;
   logic          accept, enter_done, misalign, mem_we;
   logic [IDX_W-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, rd_word, shifted, load_val;

   logic [31:0] mem [2*DEPTH_WORDS];

   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:AW];

   assign accept = (state == IDLE) && (mem_r || mem_w);

   // With LATENCY = 1 the access happens on the accepting edge, so the live inputs are used there.
   always_comb begin
      if (state == IDLE) begin
         cur_addr  = addr[AW-1:0];
         cur_wdata = wdata;
         cur_size  = size;
         cur_uns   = uns;
         cur_dbank = i_d_mem;
         cur_rd    = mem_r;
         cur_wr    = mem_w;
      end else begin
         cur_addr  = lat_addr;
         cur_wdata = lat_wdata;
         cur_size  = lat_size;
         cur_uns   = lat_uns;
         cur_dbank = lat_dbank;
         cur_rd    = lat_rd;
         cur_wr    = lat_wr;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx   = CNT_INIT;
               state_nx = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
            if (cnt <= 3'd1) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign enter_done = (state_nx == DONE) && (state != DONE);

   // Instruction fetches are always full words.
   assign eff_size = cur_dbank ? cur_size : 2'd2;
   assign idx      = cur_addr[AW-1:2];

   always_comb begin
      off       = 2'b00;
      be        = 4'b1111;
      wdata_rep = cur_wdata;
      case (eff_size)
         2'd0: begin
            off       = cur_addr[1:0];
            be        = 4'b0001 << cur_addr[1:0];
            wdata_rep = {4{cur_wdata[7:0]}};
         end
         2'd1: begin
            off       = {cur_addr[1], 1'b0};
            be        = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{cur_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign rd_word = mem[{cur_dbank, idx}];
   assign shifted = rd_word >> {off, 3'b000};

   always_comb begin
      load_val = shifted;
      case (eff_size)
         2'd0:    load_val = cur_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'd1:    load_val = cur_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = ((eff_size == 2'd1) && cur_addr[0]) ||
                     (eff_size[1] && (cur_addr[1:0] != 2'b00));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= enter_done && misalign;
   end
`else
   assign misalign = 1'b0;
   assign err      = 1'b0;
`endif

   // Only the data bank is writable; the instruction half of the array is read-only.
   assign mem_we = !rst && enter_done && cur_wr && cur_dbank && !misalign;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[{1'b1, idx}][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         rdata     <= 32'd0;
         mem_ready <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= 32'd0;
         lat_size  <= 2'd0;
         lat_uns   <= 1'b0;
         lat_dbank <= 1'b0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         mem_ready <= enter_done;
         if (accept) begin
            lat_addr  <= addr[AW-1:0];
            lat_wdata <= wdata;
            lat_size  <= size;
            lat_uns   <= uns;
            lat_dbank <= i_d_mem;
            lat_rd    <= mem_r;
            lat_wr    <= mem_w;
         end
         if (enter_done && !misalign) begin
            if (cur_wr && cur_rd) rdata <= 32'd0;
            else if (!cur_wr)     rdata <= load_val;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_mc.sv
// tb_mem_resp_mc: directed, table-driven self-checking bench for mem_resp_mc.
`default_nettype none

module tb_mem_resp_mc;

   localparam int LAT   = 2;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_d_mem, mem_r, mem_w, uns;
   logic [31:0] addr, wdata;
   logic [1:0]  size;
   logic [31:0] rdata;
   logic        mem_ready, err;

   int checks = 0;
   int fails  = 0;

   mem_resp_mc #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .i_d_mem(i_d_mem), .mem_r(mem_r), .mem_w(mem_w),
      .addr(addr), .wdata(wdata), .size(size), .uns(uns),
      .rdata(rdata), .mem_ready(mem_ready), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dbank;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_d_mem = 1'b1; mem_r = 1'b0; mem_w = 1'b0;
      addr = 32'd0; wdata = 32'd0; size = 2'd2; uns = 1'b0;
   endtask

   // Issue one request, measure acceptance-to-ready latency and return the completion outputs.
   task automatic do_req(input logic db, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic u,
                         input string tag, output logic [31:0] got_rdata, output logic got_err);
      int n;
      bit seen;
      @(negedge clk);
      i_d_mem = db; mem_r = rd; mem_w = wr; addr = a; wdata = wd; size = sz; uns = u;
      @(posedge clk);
      n = 1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) idle_inputs();
         if (mem_ready) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         n++;
      end
      got_rdata = rdata;
      got_err   = err;
      check({tag, " ready_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, 32'(n), 32'(LAT));
      @(negedge clk);
      check({tag, " ready_one_cycle"}, 32'(mem_ready), 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          pulses;
      bit          saw_ready;

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset rdata", rdata, 32'd0);
      check("reset mem_ready", 32'(mem_ready), 32'd0);
      check("reset err", 32'(err), 32'd0);
      rst = 1'b0;

      // Prior value at 0x10, then a store to 0x10 abandoned by reset in WAIT.
      do_req(1, 0, 1, 32'h10, 32'hCAFEF00D, 2'd2, 0, "init_st10", r, e);
      @(negedge clk);
      i_d_mem = 1; mem_w = 1; addr = 32'h10; wdata = 32'hDEADBEEF; size = 2'd2;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      saw_ready = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_ready) saw_ready = 1;
      end
      check("rst_wait no_ready", 32'(saw_ready), 32'd0);
      check("rst_wait rdata", rdata, 32'd0);
      rst = 1'b0;
      do_req(1, 1, 0, 32'h10, 32'd0, 2'd2, 0, "ld10_after_rst", r, e);
      check("ld10_after_rst rdata", r, 32'hCAFEF00D);

      vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h020, 32'h12345678, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h020, 32'h0,        2'd2, 1'b0, 32'h12345678, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h021, 32'h000000AB, 2'd0, 1'b0, 32'h12345678, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h020, 32'h0,        2'd2, 1'b0, 32'h1234AB78, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h021, 32'h0,        2'd0, 1'b0, 32'hFFFFFFAB, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h021, 32'h0,        2'd0, 1'b1, 32'h000000AB, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h022, 32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h020, 32'h0,        2'd1, 1'b1, 32'h0000AB78, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h020, 32'h0,        2'd1, 1'b0, 32'hFFFFAB78, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h022, 32'h0000BEEF, 2'd1, 1'b0, 32'hFFFFAB78, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h023, 32'h0,        2'd0, 1'b0, 32'hFFFFFFBE, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h024, 32'h00000005, 2'd2, 1'b0, 32'h00000000, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h024, 32'h0,        2'd2, 1'b0, 32'h00000005, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h000, 32'h11111111, 2'd2, 1'b0, 32'h00000005, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h000, 32'h99999999, 2'd2, 1'b0, 32'h00000005, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h000, 32'h0,        2'd2, 1'b0, 32'h11111111, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h400, 32'h77777777, 2'd2, 1'b0, 32'h11111111, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h000, 32'h0,        2'd2, 1'b0, 32'h77777777, 1'b0};
`ifdef MEM_MISALIGN_CHECK_EN
      vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h022, 32'h0,        2'd2, 1'b0, 32'h77777777, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h023, 32'h0,        2'd1, 1'b1, 32'h77777777, 1'b1};
`else
      vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h022, 32'h0,        2'd2, 1'b0, 32'hBEEFAB78, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h023, 32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0};
`endif

      for (int i = 0; i < 20; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         do_req(vecs[i].dbank, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                vecs[i].sz, vecs[i].u, tag, r, e);
         check({tag, " rdata"}, r, vecs[i].exp_rdata);
         check({tag, " err"}, 32'(e), 32'(vecs[i].exp_err));
      end

      // Held read: address change during WAIT is ignored, then the held request is re-accepted.
      @(negedge clk);
      i_d_mem = 1; mem_r = 1; mem_w = 0; addr = 32'h20; size = 2'd2; uns = 0;
      @(posedge clk);
      @(negedge clk);
      addr = 32'h24;
      pulses = 0;
      for (int ed = 1; ed <= 8; ed++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_ready) begin
            pulses++;
            if (pulses == 1) begin
               check("hold first_edge", 32'(ed), 32'd1);
               check("hold first_rdata", rdata, 32'hBEEFAB78);
            end else if (pulses == 2) begin
               check("hold second_edge", 32'(ed), 32'd4);
               check("hold second_rdata", rdata, 32'h00000005);
               idle_inputs();
            end
         end
      end
      check("hold pulse_count", 32'(pulses), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
